// File: rtl/key_repeat_pulse.sv
// Debounces a synchronized key level and emits one-cycle press/auto-repeat pulses with a saturating count.
// Press pulse appears 1 cycle after the DEBOUNCE_CYCLES-th press sample; no backpressure: pulse is a one-shot event.
module key_repeat_pulse #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_PERIOD   = 4
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       in,
    output logic       pulse,
    output logic       level,
    output logic [7:0] count
);
    localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int DW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW      = $clog2(TMR_MAX + 1);

    localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] DEB_ONE     = DW'(1);
    localparam logic [TW-1:0] DELAY_LAST  = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);

    typedef enum logic [2:0] {
        IDLE,
        DEB_PRESS,
        HOLD,
        REPEAT,
        DEB_RELEASE
    } state_t;

    state_t        state_q, state_d;
    state_t        origin_q, origin_d;
    logic [DW-1:0] deb_q, deb_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          pulse_d;
    logic          level_d;
    logic [7:0]    count_d;

    state_t        run_st;
    logic          run_hit;
    logic          run_step;

    // The timer compare depends on which held state owns it, including while parked in DEB_RELEASE.
    always_comb begin
        run_st  = (state_q == DEB_RELEASE) ? origin_q : state_q;
        run_hit = (run_st == HOLD) ? (tmr_q == DELAY_LAST) : (tmr_q == PERIOD_LAST);
    end

    always_comb begin
        state_d  = state_q;
        origin_d = origin_q;
        deb_d    = deb_q;
        tmr_d    = tmr_q;
        pulse_d  = 1'b0;
        level_d  = level;
        count_d  = count;
        run_step = 1'b0;

        case (state_q)
            IDLE: begin
                if (in) begin
                    state_d = DEB_PRESS;
                    deb_d   = DEB_ONE;
                end
            end
            DEB_PRESS: begin
                if (!in) begin
                    state_d = IDLE;
                    deb_d   = '0;
                end else if (deb_q == DEB_LAST) begin
                    state_d = HOLD;
                    deb_d   = '0;
                    pulse_d = 1'b1;
                    level_d = 1'b1;
                    count_d = 8'd1;
                    tmr_d   = '0;
                end else begin
                    deb_d = deb_q + DEB_ONE;
                end
            end
            HOLD, REPEAT: begin
                if (!in) begin
                    state_d  = DEB_RELEASE;
                    origin_d = state_q;
                    deb_d    = DEB_ONE;
                end else begin
                    run_step = 1'b1;
                end
            end
            DEB_RELEASE: begin
                if (in) begin
                    // Bounce rejected: resume the frozen timer on this very edge.
                    state_d  = origin_q;
                    deb_d    = '0;
                    run_step = 1'b1;
                end else if (deb_q == DEB_LAST) begin
                    state_d = IDLE;
                    deb_d   = '0;
                    level_d = 1'b0;
                end else begin
                    deb_d = deb_q + DEB_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (run_step) begin
            if (run_hit) begin
                pulse_d = 1'b1;
                count_d = (count == 8'hFF) ? count : count + 8'd1;
                state_d = REPEAT;
                tmr_d   = '0;
            end else begin
                tmr_d = tmr_q + TW'(1);
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q  <= IDLE;
            origin_q <= IDLE;
            deb_q    <= '0;
            tmr_q    <= '0;
            pulse    <= 1'b0;
            level    <= 1'b0;
            count    <= 8'd0;
        end else begin
            state_q  <= state_d;
            origin_q <= origin_d;
            deb_q    <= deb_d;
            tmr_q    <= tmr_d;
            pulse    <= pulse_d;
            level    <= level_d;
            count    <= count_d;
        end
    end

endmodule

// File: tb/tb_key_repeat_pulse.sv
// Directed bench for key_repeat_pulse: default instance plus a REPEAT_DELAY=1/REPEAT_PERIOD=1 instance.
// Inputs change and outputs are sampled on the falling edge, away from the active rising edge.
module tb_key_repeat_pulse;
    logic       Clock = 1'b0;
    logic       Reset;
    logic       in;
    logic       in_fast;
    logic       pulse, level;
    logic       pulse_fast, level_fast;
    logic [7:0] count, count_fast;

    int n_checks = 0;
    int n_errors = 0;

    always #5 Clock = ~Clock;

    key_repeat_pulse dut (
        .Clock (Clock),
        .Reset (Reset),
        .in    (in),
        .pulse (pulse),
        .level (level),
        .count (count)
    );

    key_repeat_pulse #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (1),
        .REPEAT_PERIOD   (1)
    ) dut_fast (
        .Clock (Clock),
        .Reset (Reset),
        .in    (in_fast),
        .pulse (pulse_fast),
        .level (level_fast),
        .count (count_fast)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk3(input string tag, input logic ep, input logic el, input logic [7:0] ec);
        chk({tag, ".pulse"}, {7'd0, pulse}, {7'd0, ep});
        chk({tag, ".level"}, {7'd0, level}, {7'd0, el});
        chk({tag, ".count"}, count, ec);
    endtask

    task automatic chkf(input string tag, input logic ep, input logic el, input logic [7:0] ec);
        chk({tag, ".pulse"}, {7'd0, pulse_fast}, {7'd0, ep});
        chk({tag, ".level"}, {7'd0, level_fast}, {7'd0, el});
        chk({tag, ".count"}, count_fast, ec);
    endtask

    initial begin
        logic       exp_p;
        logic [7:0] exp_c;

        // Reset held with the key already down
        Reset   = 1'b0;
        in      = 1'b1;
        in_fast = 1'b0;
        repeat (2) @(negedge Clock);
        chk3("reset", 1'b0, 1'b0, 8'd0);

        // Release reset with in=1: full debounce, pulse after 4th sampling edge
        Reset = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge Clock);
            chk3("deb_press", 1'b0, 1'b0, 8'd0);
        end
        @(negedge Clock);
        chk3("press", 1'b1, 1'b1, 8'd1);

        // Held key: repeats at P+16, then every 4 cycles
        for (int k = 1; k <= 40; k++) begin
            @(negedge Clock);
            exp_p = (k >= 16) && (((k - 16) % 4) == 0);
            exp_c = (k >= 16) ? 8'(2 + (k - 16) / 4) : 8'd1;
            chk3("hold", exp_p, 1'b1, exp_c);
        end

        // Two-sample bounce in REPEAT: next repeat at P+46 instead of P+44
        in = 1'b0;
        for (int k = 41; k <= 42; k++) begin
            @(negedge Clock);
            chk3("bounce", 1'b0, 1'b1, 8'd8);
        end
        in = 1'b1;
        for (int k = 43; k <= 46; k++) begin
            @(negedge Clock);
            chk3("bounce_resume", (k == 46), 1'b1, (k == 46) ? 8'd9 : 8'd8);
        end

        // Real release: level falls after the 4th zero sample, count retained
        in = 1'b0;
        for (int k = 47; k <= 49; k++) begin
            @(negedge Clock);
            chk3("deb_release", 1'b0, 1'b1, 8'd9);
        end
        @(negedge Clock);
        chk3("release", 1'b0, 1'b0, 8'd9);
        repeat (3) begin
            @(negedge Clock);
            chk3("idle_hold_count", 1'b0, 1'b0, 8'd9);
        end

        // New press reloads count with 1, then reaches REPEAT
        in = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge Clock);
            chk3("repress_deb", 1'b0, 1'b0, 8'd9);
        end
        @(negedge Clock);
        chk3("repress", 1'b1, 1'b1, 8'd1);
        for (int k = 1; k <= 18; k++) begin
            @(negedge Clock);
            chk3("hold2", (k == 16), 1'b1, (k >= 16) ? 8'd2 : 8'd1);
        end

        // Reset mid-REPEAT with key still held
        Reset = 1'b0;
        @(negedge Clock);
        chk3("reset_mid", 1'b0, 1'b0, 8'd0);
        Reset = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge Clock);
            chk3("post_reset_deb", 1'b0, 1'b0, 8'd0);
        end
        @(negedge Clock);
        chk3("post_reset_press", 1'b1, 1'b1, 8'd1);

        in = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge Clock);
            chk3("release2_deb", 1'b0, 1'b1, 8'd1);
        end
        @(negedge Clock);
        chk3("release2", 1'b0, 1'b0, 8'd1);
        Reset = 1'b0;
        @(negedge Clock);
        chk3("reset_idle", 1'b0, 1'b0, 8'd0);
        Reset = 1'b1;

        // Glitch: 3 high samples then low on the would-be accepting edge
        in = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge Clock);
            chk3("glitch_high", 1'b0, 1'b0, 8'd0);
        end
        in = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge Clock);
            chk3("glitch_low", 1'b0, 1'b0, 8'd0);
        end

        // Fast instance: pulse every cycle, count saturates at 255
        in_fast = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge Clock);
            chkf("fast_deb", 1'b0, 1'b0, 8'd0);
        end
        @(negedge Clock);
        chkf("fast_press", 1'b1, 1'b1, 8'd1);
        for (int k = 1; k <= 299; k++) begin
            @(negedge Clock);
            exp_c = (k + 1 >= 255) ? 8'd255 : 8'(k + 1);
            chkf("fast_repeat", 1'b1, 1'b1, exp_c);
        end
        in_fast = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/key_repeat_pulse.md
Name: key_repeat_pulse

Overview:
Debounces an already-synchronized key level and converts a press into single-cycle pulses. The block sits directly downstream of the two-flop input synchronizer and takes that synchronizer's output as its `in`. It emits one pulse on a debounced press. If the key is held, it then auto-repeats after a delay and keeps a saturating per-press pulse count. Game and counter logic consume `pulse` as a one-shot "key event".

Parameters:
DEBOUNCE_CYCLES, 4, consecutive equal samples needed to accept a press or release; must be >=2.
REPEAT_DELAY, 16, cycles from the first press pulse to the first repeat pulse; must be >=1.
REPEAT_PERIOD, 4, cycles between successive repeat pulses; must be >=1.

Ports:
Clock  input  1  system clock; all state updates on posedge.
Reset  input  1  synchronous, active-low reset: Reset==0 at a posedge resets the block; Reset==1 is normal operation.
in     input  1  synchronized key level; 1 = pressed.
pulse  output 1  one-cycle press/repeat event, registered.
level  output 1  debounced key level, registered.
count  output 8  pulses emitted during the current press, saturating at 255; holds its value after release.

Behaviour:
- Reset (Reset==0 at a posedge):
  - state=IDLE; pulse=0, level=0, count=0; all timers cleared.
  - Applies from any state, including mid-debounce or mid-repeat.
  - After reset releases with in already 1, a full press debounce is required.
- All outputs are registered; there is no combinational path from in to any output.
- States: IDLE, DEB_PRESS, HOLD, REPEAT, DEB_RELEASE.
- IDLE (level=0):
  - in=1 -> DEB_PRESS with debounce counter=1.
- DEB_PRESS:
  - in=1 -> counter+1.
  - When a sample makes the counter equal DEBOUNCE_CYCLES -> HOLD. On that same edge: pulse<=1, level<=1, count<=1, hold timer<=0.
  - in=0 before that point -> IDLE, counter cleared, no pulse.
  - Press latency: pulse is high in the cycle after the DEBOUNCE_CYCLES-th consecutive posedge that samples in=1.
- HOLD (level=1):
  - Hold timer increments each cycle.
  - The cycle that is REPEAT_DELAY cycles after the press-pulse cycle carries a pulse; count increments (saturating); state -> REPEAT; timer<=0.
- REPEAT (level=1):
  - A pulse every REPEAT_PERIOD cycles, measured from the previous pulse cycle. Each pulse increments count, saturating at 255.
  - Pulses continue after count saturates.
- In HOLD or REPEAT, in=0 -> DEB_RELEASE.
  - Record the origin state (HOLD or REPEAT).
  - Release counter=1; the hold/repeat timer freezes.
- DEB_RELEASE (level stays 1, no pulses):
  - in=0 -> release counter+1. On reaching DEBOUNCE_CYCLES: level<=0, state -> IDLE, no pulse emitted; count retains its value.
  - in=1 before that -> return to the origin state. The frozen timer resumes, so the next repeat is delayed by the number of cycles spent in DEB_RELEASE.
- pulse is never high on two consecutive cycles unless REPEAT_PERIOD==1 in REPEAT.
  - Likewise if REPEAT_DELAY==1, the first repeat directly follows the press pulse.
- count is only cleared by reset; a new press loads it with 1.
- Counter widths are sized from the parameters so that no counter can wrap before its compare point.
- Simultaneous events:
  - Reset==0 overrides all else.
  - In DEB_PRESS, in=0 on the edge that would reach DEBOUNCE_CYCLES means the press is not accepted.

Test Plan:
1. Defaults. Hold Reset=0 for 2 cycles with in=1 -> pulse=0, level=0, count=0. Drive Reset=1 with in=1 held -> the pulse cycle follows the 4th sampling posedge, and level=1 from that cycle on.
2. Glitch. in=1 for 3 posedges, then 0 -> pulse never high, level=0, count=0.
3. Hold in=1 for 40 cycles after press pulse at cycle P -> pulses at P, P+16, P+20, P+24, P+28, ...; count reads 1, 2, 3, 4, 5.
4. Bounce while in REPEAT:
   - Drop in to 0 for 2 cycles, then back to 1 -> level stays 1, and the next repeat pulse arrives 2 cycles late.
   - Later drop in to 0 for 4 cycles -> level falls after the 4th zero sample, no release pulse, count unchanged.
5. Reset mid-REPEAT: Reset=0 for one edge with in held 1 -> the next cycle has pulse=0, level=0, count=0. After Reset=1, the next press pulse comes only after 4 sampling edges.
6. Saturation: override REPEAT_DELAY=1, REPEAT_PERIOD=1 and hold in=1 for 300 cycles -> count stops at 255 while pulse stays high every cycle.
